sound_sequencer: RTL and testbench
==================================

# sound_sequencer

Multi-channel successor to the single-event sound FSM. Captures rising-edge sound requests from `NUM_CH` game-event channels, queues them as pending bits, and plays them one at a time by fixed priority, each for a programmable duration in clock cycles. It keeps the button-driven ON/OFF mute mode and sits between the game-logic event sources and the tone/speaker driver, which consumes `playSound` and `tone_o`.

## Interface
- `NUM_CH`, default 4: number of event channels, minimum 2; channel 0 has the highest priority.
- `DUR_W`, default 8: width of each channel's duration field.
- `ID_W`, default `$clog2(NUM_CH)`: width of the channel ID.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `button`  in  1: mute toggle request; the block edge-detects it internally.
- `event_i`  in  NUM_CH: per-channel sound request, level or pulse.
- `dur_cfg_i`  in  NUM_CH*DUR_W: packed per-channel durations; channel k uses bits [k*DUR_W +: DUR_W].
- `playSound`  out  1: tone active.
- `tone_o`  out  ID_W: channel currently playing, or the last channel played.
- `mode_o`  out  1: 1 = ON (sound enabled), 0 = OFF (muted).
- `busy_o`  out  1: high when the FSM is not IDLE or any pending bit is set.

## Operation
- Edge detect:
  - `btn_rise` = `button` & ~`button_q`.
  - `ev_rise[k]` = `event_i[k]` & ~`event_q[k]`.
  - `button_q` and `event_q` are registered copies of the inputs.
- Mode:
  - `btn_rise` toggles `mode_o`.
  - Toggling to OFF clears all pending bits and aborts any tone; the FSM goes to IDLE on that same edge.
- Accept rule: `ev_rise[k]` sets `pending[k]` only if `mode_o`==1 and `btn_rise`==0 on that edge.
  - Otherwise the request is discarded.
  - A request on a channel that is already pending is merged into the existing bit.
- FSM states: IDLE, PLAY, GAP.
- IDLE → PLAY when any source in (`pending` | accepted `ev_rise`) is set.
  - The lowest-index source wins.
  - Its pending bit is cleared, `tone_o` is loaded with its index, and `cnt` is loaded with max(`dur_cfg[k]`, 1).
  - A duration of 0 plays for 1 cycle.
- PLAY: `cnt` decrements each cycle; when `cnt`==1 the FSM goes to GAP.
- GAP: lasts exactly 1 cycle with `playSound` low, then returns to IDLE logic. If work is pending, GAP → PLAY directly.
- `playSound` is a registered output, high exactly while the state is PLAY.
- `dur_cfg_i` is sampled only when a tone is loaded; changing it mid-tone has no effect.
- A new edge on the channel currently playing sets its pending bit, so the tone replays after GAP.

## Timing
- Reset values:
  - Outputs: `playSound`=0, `tone_o`=0, `mode_o`=1 (ON), `busy_o`=0.
  - Internal: state IDLE, `pending`=0, `cnt`=0, `button_q`=0, `event_q`=0.
- Reset mid-tone drops `playSound` asynchronously and discards the pending queue.
- Latency: `event_i[k]` first sampled high at edge n (from IDLE) gives `playSound`=1 and `tone_o`=k after edge n.
- Tone length: `playSound` stays high for exactly D = max(dur,1) cycles.
- Back-to-back tones are separated by exactly one low cycle.
- A held level on `event_i` yields one tone only; the channel must drop for at least one cycle to re-request.
- Mute: `btn_rise` at edge m while ON gives `mode_o`=0 and `playSound`=0 after edge m.
- Simultaneous requests on several channels in one cycle: all become pending and are served in ascending index order.

## Configuration
- `SOUND_PREEMPT_EN` defined:
  - In PLAY, if any pending index < `tone_o`, the current tone is abandoned and not re-queued.
  - The FSM stays in PLAY with the new channel: `tone_o` and `cnt` are reloaded on that edge and `playSound` stays high with no GAP.
  - An equal or lower-priority request never preempts.
- `SOUND_PREEMPT_EN` undefined: a tone always runs to completion, and pending requests wait for GAP.

## Test plan
- Reset check: assert `rst` for 2 cycles and release between edges → `mode_o`=1, `playSound`=0, `busy_o`=0, `tone_o`=0.
- Single tone: dur ch2=3, pulse `event_i[2]` for 1 cycle → `playSound` high 3 cycles starting the cycle after the edge, `tone_o`=2, then 1 low cycle, then `busy_o`=0.
- Simultaneous requests: dur=2 on all channels, `event_i`=4'b1001 for 1 cycle → tone on ch0 for 2 cycles, 1 gap cycle, ch3 for 2 cycles.
- Held level and zero duration: hold `event_i[1]` high 10 cycles with dur=0 → exactly one 1-cycle tone.
- Mute: press `button` mid-tone → `playSound`=0 and `mode_o`=0 the next cycle. Then pulse `event_i[0]` → no tone. Press again → `mode_o`=1 and new events play.
- Preempt: dur ch3=6; start ch3, then pulse ch1 at tone cycle 2.
  - With `SOUND_PREEMPT_EN`: `tone_o` switches 3→1 without a low cycle, and ch1 plays for its full duration.
  - Without it: ch3 completes 6 cycles, 1 gap cycle, then ch1 plays.

Source files
------------

// File: rtl/sound_sequencer.sv
// Multi-channel sound sequencer: edge-captured requests, fixed-priority playback, ON/OFF mute; preemption under SOUND_PREEMPT_EN.
// Latency: request rising at edge n plays from edge n for max(dur,1) cycles, then one low GAP cycle.
// No backpressure: requests merge into per-channel pending bits; muted or same-edge-as-button requests are dropped.
module sound_sequencer #(
    parameter int NUM_CH = 4,
    parameter int DUR_W  = 8,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    button,
    input  logic [NUM_CH-1:0]       event_i,
    input  logic [NUM_CH*DUR_W-1:0] dur_cfg_i,
    output logic                    playSound,
    output logic [ID_W-1:0]         tone_o,
    output logic                    mode_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [NUM_CH-1:0]   pending, pending_n;
    logic [NUM_CH-1:0]   event_q;
    logic                button_q;
    logic [DUR_W-1:0]    cnt, cnt_n;
    logic [ID_W-1:0]     tone_n;
    logic                mode_n;

    logic                btn_rise;
    logic [NUM_CH-1:0]   ev_rise;
    logic [NUM_CH-1:0]   accept;
    logic [NUM_CH-1:0]   src;
    logic [NUM_CH-1:0]   src_clr;
    logic                src_any;
    logic [ID_W-1:0]     src_idx;
    logic [DUR_W-1:0]    src_dur;
    logic [DUR_W-1:0]    load_cnt;

    // Request capture and lowest-index selection over pending plus this edge's accepted requests.
    always_comb begin
        btn_rise = button & ~button_q;
        ev_rise  = event_i & ~event_q;
        accept   = (mode_o && !btn_rise) ? ev_rise : '0;
        src      = pending | accept;
        src_any  = |src;
        src_idx  = '0;
        src_dur  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (src[k]) begin
                src_idx = ID_W'(k);
                src_dur = dur_cfg_i[k*DUR_W +: DUR_W];
            end
        end
        load_cnt = (src_dur == '0) ? DUR_W'(1) : src_dur;
        src_clr  = src & ~(NUM_CH'(1) << src_idx);
    end

    always_comb begin
        state_n   = state;
        pending_n = src;
        tone_n    = tone_o;
        cnt_n     = cnt;
        mode_n    = mode_o ^ btn_rise;
        if (btn_rise && mode_o) begin
            // Muting aborts everything on the same edge.
            state_n   = IDLE;
            pending_n = '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (src_any) begin
                        state_n   = PLAY;
                        tone_n    = src_idx;
                        cnt_n     = load_cnt;
                        pending_n = src_clr;
                    end else begin
                        state_n = IDLE;
                    end
                end
                PLAY: begin
`ifdef SOUND_PREEMPT_EN
                    if (src_any && (src_idx < tone_o)) begin
                        tone_n    = src_idx;
                        cnt_n     = load_cnt;
                        pending_n = src_clr;
                    end else
`endif
                    if (cnt == DUR_W'(1)) begin
                        state_n = GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - DUR_W'(1);
                    end
                end
                default: begin
                    state_n   = IDLE;
                    pending_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            event_q   <= '0;
            button_q  <= 1'b0;
            cnt       <= '0;
            tone_o    <= '0;
            mode_o    <= 1'b1;
            playSound <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            event_q   <= event_i;
            button_q  <= button;
            cnt       <= cnt_n;
            tone_o    <= tone_n;
            mode_o    <= mode_n;
            playSound <= (state_n == PLAY);
        end
    end

    assign busy_o = (state != IDLE) || (|pending);

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer; expectations for the preempt step follow SOUND_PREEMPT_EN.
module tb_sound_sequencer;

    logic        tb_clk;
    logic        rst;
    logic        button;
    logic [3:0]  event_i;
    logic [31:0] dur_cfg;
    logic        playSound;
    logic [1:0]  tone_o;
    logic        mode_o;
    logic        busy_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    sound_sequencer #(.NUM_CH(4), .DUR_W(8)) dut (
        .clk       (tb_clk),
        .rst       (rst),
        .button    (button),
        .event_i   (event_i),
        .dur_cfg_i (dur_cfg),
        .playSound (playSound),
        .tone_o    (tone_o),
        .mode_o    (mode_o),
        .busy_o    (busy_o)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge tb_clk);
    endtask

    int hi_cnt;

    initial begin
        rst     = 1'b1;
        button  = 1'b0;
        event_i = 4'b0000;
        dur_cfg = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mode", 32'(mode_o), 1);
        chk("rst_play", 32'(playSound), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_tone", 32'(tone_o), 0);
        tick();

        // Single tone, ch2 dur 3
        dur_cfg = {8'd0, 8'd3, 8'd0, 8'd0};
        event_i = 4'b0100;
        tick();
        chk("single_play0", 32'(playSound), 1);
        chk("single_tone", 32'(tone_o), 2);
        chk("single_busy", 32'(busy_o), 1);
        event_i = 4'b0000;
        tick();
        chk("single_play1", 32'(playSound), 1);
        tick();
        chk("single_play2", 32'(playSound), 1);
        tick();
        chk("single_gap", 32'(playSound), 0);
        chk("single_gap_busy", 32'(busy_o), 1);
        tick();
        chk("single_idle_busy", 32'(busy_o), 0);
        chk("single_idle_play", 32'(playSound), 0);

        // Simultaneous ch0 and ch3, dur 2 each
        dur_cfg = {4{8'd2}};
        event_i = 4'b1001;
        tick();
        chk("sim_p0", 32'(playSound), 1);
        chk("sim_t0", 32'(tone_o), 0);
        event_i = 4'b0000;
        tick();
        chk("sim_p1", 32'(playSound), 1);
        chk("sim_t1", 32'(tone_o), 0);
        tick();
        chk("sim_gap", 32'(playSound), 0);
        chk("sim_gap_busy", 32'(busy_o), 1);
        tick();
        chk("sim_p3", 32'(playSound), 1);
        chk("sim_t3", 32'(tone_o), 3);
        tick();
        chk("sim_p4", 32'(playSound), 1);
        tick();
        chk("sim_gap2", 32'(playSound), 0);
        tick();
        chk("sim_done", 32'(busy_o), 0);

        // Held level on ch1 with zero duration
        dur_cfg = 32'h0;
        event_i = 4'b0010;
        hi_cnt  = 0;
        tick();
        chk("held_first", 32'(playSound), 1);
        chk("held_tone", 32'(tone_o), 1);
        for (int i = 0; i < 13; i++) begin
            if (playSound) hi_cnt++;
            if (i == 9) event_i = 4'b0000;
            tick();
        end
        chk("held_count", 32'(hi_cnt), 1);
        chk("held_busy", 32'(busy_o), 0);

        // Mute mid-tone, muted request dropped, unmute
        dur_cfg = {8'd0, 8'd5, 8'd0, 8'd0};
        event_i = 4'b0100;
        tick();
        chk("mute_pre_play", 32'(playSound), 1);
        event_i = 4'b0000;
        button  = 1'b1;
        tick();
        chk("mute_play", 32'(playSound), 0);
        chk("mute_mode", 32'(mode_o), 0);
        chk("mute_busy", 32'(busy_o), 0);
        button  = 1'b0;
        event_i = 4'b0001;
        hi_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            event_i = 4'b0000;
            if (playSound || busy_o) hi_cnt++;
        end
        chk("mute_drop", 32'(hi_cnt), 0);
        button = 1'b1;
        tick();
        chk("unmute_mode", 32'(mode_o), 1);
        chk("unmute_play", 32'(playSound), 0);
        button  = 1'b0;
        event_i = 4'b0001;
        tick();
        chk("unmute_tone_play", 32'(playSound), 1);
        chk("unmute_tone_id", 32'(tone_o), 0);
        event_i = 4'b0000;
        tick();
        chk("unmute_tone_gap", 32'(playSound), 0);
        tick();

        // Preempt: ch3 dur 6, ch1 dur 2 requested during ch3 tone cycle 2
        dur_cfg = {8'd6, 8'd0, 8'd2, 8'd0};
        event_i = 4'b1000;
        tick();
        chk("pre_t3_a", 32'(tone_o), 3);
        event_i = 4'b0000;
        tick();
        chk("pre_t3_b", 32'(playSound), 1);
        event_i = 4'b0010;
        tick();
        event_i = 4'b0000;
`ifdef SOUND_PREEMPT_EN
        chk("pre_switch_play", 32'(playSound), 1);
        chk("pre_switch_tone", 32'(tone_o), 1);
        tick();
        chk("pre_ch1_play", 32'(playSound), 1);
        chk("pre_ch1_tone", 32'(tone_o), 1);
        tick();
        chk("pre_gap", 32'(playSound), 0);
        tick();
        chk("pre_done", 32'(busy_o), 0);
`else
        hi_cnt = 2;
        for (int i = 0; i < 4; i++) begin
            if (playSound && tone_o == 2'd3) hi_cnt++;
            tick();
        end
        chk("nopre_ch3_len", 32'(hi_cnt), 6);
        chk("nopre_gap", 32'(playSound), 0);
        chk("nopre_gap_busy", 32'(busy_o), 1);
        tick();
        chk("nopre_ch1_play", 32'(playSound), 1);
        chk("nopre_ch1_tone", 32'(tone_o), 1);
        tick();
        chk("nopre_ch1_play2", 32'(playSound), 1);
        tick();
        chk("nopre_gap2", 32'(playSound), 0);
        tick();
        chk("nopre_done", 32'(busy_o), 0);
`endif

        // Asynchronous reset mid-tone
        dur_cfg = {8'd6, 8'd0, 8'd0, 8'd0};
        event_i = 4'b1000;
        tick();
        event_i = 4'b0000;
        tick();
        chk("arst_pre", 32'(playSound), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_play", 32'(playSound), 0);
        chk("arst_busy", 32'(busy_o), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_after", 32'(playSound), 0);
        chk("arst_mode", 32'(mode_o), 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
